// File: rtl/vape_pkg.sv
// vape_pkg: shared FSM states, reset-handler default and cycle-counter width for the ER tracker
package vape_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, ABORT = 2'd3} state_t;
  localparam logic [15:0] RESET_HANDLER_DEF = 16'h0000;
  localparam int CYC_W = 16;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;
endpackage

// File: rtl/vape_er_exec_track_if.sv
// vape_er_exec_track_if: CPU/DMA observation bus and attestation outputs of the ER tracker
interface vape_er_exec_track_if;
  logic [15:0] pc, data_addr, dma_addr, ER_min, ER_max, er_cycles;
  logic irq, data_en, dma_en, exec, er_busy;
  modport master(output pc, irq, data_addr, data_en, dma_addr, dma_en, ER_min, ER_max,
                 input exec, er_busy, er_cycles);
  modport slave(input pc, irq, data_addr, data_en, dma_addr, dma_en, ER_min, ER_max,
                output exec, er_busy, er_cycles);
endinterface

// File: rtl/vape_range_cmp.sv
// vape_range_cmp: unsigned inclusive address-in-range check
module vape_range_cmp (
  input  logic [15:0] addr_i,
  input  logic [15:0] lo_i,
  input  logic [15:0] hi_i,
  output logic        in_o
);
  assign in_o = (addr_i >= lo_i) && (addr_i <= hi_i);
endmodule

// File: rtl/vape_er_exec_track.sv
// vape_er_exec_track: tracks atomic, unmodified execution of the executable region ER_min..ER_max
// Define VAPE_IRQ_ABORT_EN to make an interrupt during an ER run abort it.
module vape_er_exec_track
  import vape_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF
) (
  input logic                  clk,
  input logic                  rst,
  vape_er_exec_track_if.slave  bus
);
  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             exec_q, busy_q;
  logic             pc_in, data_in, dma_in, wr_er, bad_idle, bad_run, irq_abt, inv;
  vape_range_cmp u_pc_cmp   (.addr_i(bus.pc),        .lo_i(bus.ER_min), .hi_i(bus.ER_max), .in_o(pc_in));
  vape_range_cmp u_data_cmp (.addr_i(bus.data_addr), .lo_i(bus.ER_min), .hi_i(bus.ER_max), .in_o(data_in));
  vape_range_cmp u_dma_cmp  (.addr_i(bus.dma_addr),  .lo_i(bus.ER_min), .hi_i(bus.ER_max), .in_o(dma_in));
`ifdef VAPE_IRQ_ABORT_EN
  assign irq_abt = bus.irq;
`else
  assign irq_abt = 1'b0;
`endif
  assign inv      = bus.ER_min > bus.ER_max;
  assign wr_er    = (bus.data_en && data_in) || (bus.dma_en && dma_in);
  assign bad_idle = pc_in && (bus.pc != bus.ER_min);
  assign bad_run  = bus.dma_en || !pc_in || irq_abt;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = (wr_er || bad_idle) ? ABORT : (bus.pc == bus.ER_min) ? RUN : state_q;
      RUN:        state_d = (wr_er || bad_run) ? ABORT : (bus.pc == bus.ER_max) ? DONE : RUN;
      default:    state_d = (bus.pc == RESET_HANDLER && !wr_er) ? IDLE : ABORT;
    endcase
    if (inv) state_d = ABORT;
  end
  // the cycle that leaves RUN for DONE still executes inside ER, so it is counted
  assign cyc_d = (state_d == ABORT) ? '0 :
                 (state_d == RUN && state_q != RUN) ? CYC_W'(1) :
                 (state_q == RUN) ? ((cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_W'(1)) : cyc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ABORT;
      cyc_q   <= '0;
      exec_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      exec_q  <= state_d == DONE;
      busy_q  <= state_d == RUN;
    end
  end
  assign bus.exec      = exec_q;
  assign bus.er_busy   = busy_q;
  assign bus.er_cycles = cyc_q;
endmodule

// File: tb/tb_vape_er_exec_track.sv
// tb_vape_er_exec_track: directed scenarios plus randomized pc/write streams against a run-tracking model
module tb_vape_er_exec_track;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  vape_er_exec_track_if bus();
  vape_er_exec_track dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic m_aborted, m_running, m_done;
  int   m_cnt;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit inside_er(input logic [15:0] a);
    return a >= bus.ER_min && a <= bus.ER_max;
  endfunction
  task automatic model(input logic [15:0] p, input logic i, input logic de, input logic [15:0] da,
                       input logic me, input logic [15:0] ma);
    bit wr, bad, irq_ab;
`ifdef VAPE_IRQ_ABORT_EN
    irq_ab = i;
`else
    irq_ab = 1'b0;
`endif
    wr = (de && inside_er(da)) || (me && inside_er(ma));
    if (bus.ER_min > bus.ER_max) begin
      m_aborted = 1; m_running = 0; m_done = 0; m_cnt = 0;
    end else if (m_aborted) begin
      if (p == 16'h0000 && !wr) m_aborted = 0;
    end else begin
      bad = wr || (m_running ? (me || !inside_er(p) || irq_ab) : (inside_er(p) && p != bus.ER_min));
      if (bad) begin
        m_aborted = 1; m_running = 0; m_done = 0; m_cnt = 0;
      end else if (m_running) begin
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (p == bus.ER_max) begin m_running = 0; m_done = 1; end
      end else if (p == bus.ER_min) begin
        m_running = 1; m_done = 0; m_cnt = 1;
      end
    end
  endtask
  task automatic step(input logic [15:0] p, input logic i = 0, input logic de = 0, input logic [15:0] da = 0,
                      input logic me = 0, input logic [15:0] ma = 0);
    bus.pc = p; bus.irq = i; bus.data_en = de; bus.data_addr = da; bus.dma_en = me; bus.dma_addr = ma;
    @(posedge clk);
    model(p, i, de, da, me, ma);
    #1;
    chk("exec", {15'd0, bus.exec}, {15'd0, m_done});
    chk("er_busy", {15'd0, bus.er_busy}, {15'd0, m_running});
    chk("er_cycles", bus.er_cycles, 16'(m_cnt));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_aborted = 1; m_running = 0; m_done = 0; m_cnt = 0;
    chk("rst_exec", {15'd0, bus.exec}, 16'd0);
    chk("rst_busy", {15'd0, bus.er_busy}, 16'd0);
    chk("rst_cycles", bus.er_cycles, 16'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic walk(input logic [15:0] lo, input logic [15:0] hi, input bit perturb);
    for (int a = lo; a <= hi; a++) begin
      if (perturb && $urandom_range(0, 24) == 0)
        case ($urandom_range(0, 3))
          0: step(16'(a), 1'b1);
          1: step(16'(a), 1'b0, 1'b1, lo + 16'($urandom_range(0, 3)));
          2: step(16'(a), 1'b0, 1'b0, 16'h0, 1'b1, 16'($urandom));
          default: step(16'($urandom_range(16'hDFF0, 16'hE020)));
        endcase
      else step(16'(a));
    end
  endtask
  initial begin
    bus.pc = 0; bus.irq = 0; bus.data_en = 0; bus.data_addr = 0; bus.dma_en = 0; bus.dma_addr = 0;
    bus.ER_min = 16'hE000; bus.ER_max = 16'hE010;
    @(negedge clk);
    do_reset();
    step(16'h0000);
    walk(16'hE000, 16'hE010, 0);
    chk("run_exec", {15'd0, bus.exec}, 16'd1);
    chk("run_cycles", bus.er_cycles, 16'd17);
    step(16'h0000, 1'b0, 1'b1, 16'hE008);
    chk("wr_exec", {15'd0, bus.exec}, 16'd0);
    chk("wr_cycles", bus.er_cycles, 16'd0);
    step(16'h0000);
    step(16'hE004);
    chk("jump_exec", {15'd0, bus.exec}, 16'd0);
    walk(16'hE000, 16'hE010, 0);
    chk("jump_norh_exec", {15'd0, bus.exec}, 16'd0);
    step(16'h0000);
    walk(16'hE000, 16'hE010, 0);
    chk("jump_rerun_exec", {15'd0, bus.exec}, 16'd1);
    step(16'h0000);
    walk(16'hE000, 16'hE005, 0);
    step(16'hE006, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0200);
    chk("dma_busy", {15'd0, bus.er_busy}, 16'd0);
    step(16'h0000);
    walk(16'hE000, 16'hE003, 0);
    step(16'hE004, 1'b1);
    walk(16'hE005, 16'hE010, 0);
`ifdef VAPE_IRQ_ABORT_EN
    chk("irq_exec", {15'd0, bus.exec}, 16'd0);
`else
    chk("irq_exec", {15'd0, bus.exec}, 16'd1);
`endif
    step(16'h0000);
    walk(16'hE000, 16'hE007, 0);
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", {15'd0, bus.er_busy}, 16'd0);
    rst = 1'b0;
    do_reset();
    walk(16'hE008, 16'hE010, 0);
    chk("midrun_rst_exec", {15'd0, bus.exec}, 16'd0);
    bus.ER_min = 16'hE005; bus.ER_max = 16'hE005;
    step(16'h0000);
    step(16'hE005);
    step(16'hE005);
    chk("single_exec", {15'd0, bus.exec}, 16'd1);
    chk("single_cycles", bus.er_cycles, 16'd2);
    bus.ER_min = 16'hE010; bus.ER_max = 16'hE000;
    for (int k = 0; k < 20; k++) step(k < 2 ? 16'h0000 : 16'hE000 + 16'($urandom_range(0, 16)));
    chk("inv_exec", {15'd0, bus.exec}, 16'd0);
    for (int s = 0; s < 200; s++) begin
      case ($urandom_range(0, 9))
        0: begin bus.ER_min = 16'hE010; bus.ER_max = 16'hE000; end
        1: begin bus.ER_min = 16'hE003; bus.ER_max = 16'hE003; end
        default: begin bus.ER_min = 16'hE000; bus.ER_max = 16'hE010; end
      endcase
      case ($urandom_range(0, 3))
        0: for (int k = 0; k < 6; k++)
             step($urandom_range(0, 3) == 0 ? 16'h0000 : 16'($urandom_range(16'hDFF8, 16'hE018)),
                  1'($urandom), $urandom_range(0, 3) == 0, 16'($urandom_range(16'hDFF8, 16'hE018)),
                  $urandom_range(0, 5) == 0, 16'($urandom_range(16'hDFF8, 16'hE018)));
        1: begin step(16'h0000); walk(bus.ER_min, bus.ER_max, 0); step(16'h1234); step(16'h0000); end
        default: begin step(16'h0000); walk(bus.ER_min, bus.ER_max, 1); end
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vape_er_exec_track.md
VAPE_ER_EXEC_TRACK -- requirements
Module: vape_er_exec_track

Interface
REQ-001 SHALL have parameter RESET_HANDLER, default 16'h0000, the PC value that marks reset completion.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port pc, input, 16 bits: current program counter.
REQ-005 SHALL have port irq, input, 1 bit: CPU interrupt acknowledge.
REQ-006 SHALL have ports data_addr, input, 16 bits, and data_en, input, 1 bit: CPU write address and strobe.
REQ-007 SHALL have ports dma_addr, input, 16 bits, and dma_en, input, 1 bit: DMA address and strobe.
REQ-008 SHALL have ports ER_min and ER_max, input, 16 bits each: inclusive executable-region bounds.
REQ-009 SHALL have port exec, output, 1 bit: 1 = ER ran atomically from ER_min to ER_max, unmodified since.
REQ-010 SHALL have port er_busy, output, 1 bit: 1 while ER execution is in progress.
REQ-011 SHALL have port er_cycles, output, 16 bits: clock cycles spent in the current or last ER run.

Function
REQ-012 SHALL implement a 4-state FSM: IDLE, RUN, DONE, ABORT.
REQ-013 Abort condition SHALL be: CPU or DMA write with address in [ER_min, ER_max]; dma_en in RUN; pc outside ER in RUN; pc inside ER but not equal to ER_min in IDLE or DONE.
REQ-014 Any abort condition in IDLE, RUN or DONE SHALL move to ABORT; abort SHALL take priority over every other transition in the same cycle.
REQ-015 ABORT -> IDLE SHALL occur when pc == RESET_HANDLER and no ER write occurs that cycle; otherwise ABORT SHALL hold.
REQ-016 IDLE -> RUN and DONE -> RUN SHALL occur when pc == ER_min.
REQ-017 RUN -> DONE SHALL occur when pc == ER_max; pc inside ER otherwise SHALL keep RUN.
REQ-018 DONE SHALL hold while pc is outside ER and no abort condition occurs.
REQ-019 When ER_min > ER_max, the FSM SHALL be forced to ABORT every cycle.
REQ-020 When ER_min == ER_max, pc == ER_min SHALL go to RUN and the following cycle's pc == ER_max SHALL go to DONE.
REQ-021 exec, er_busy and er_cycles SHALL be registered, with 1-cycle latency from the triggering input cycle.
REQ-022 exec SHALL be 1 only in DONE; er_busy SHALL be 1 only in RUN.
REQ-023 er_cycles SHALL load 1 on entry to RUN and increment each RUN cycle, saturating at 16'hFFFF.
REQ-024 er_cycles SHALL hold in DONE and clear to 0 in ABORT.
REQ-025 Range comparisons SHALL be unsigned and inclusive at both bounds.

Reset
REQ-026 rst SHALL immediately force state = ABORT, exec = 0, er_busy = 0, er_cycles = 0.
REQ-027 Reset asserted mid-RUN SHALL discard the run; exec SHALL not assert until a full ER_min..ER_max run completes after the reset handler.

Configuration
REQ-028 With VAPE_IRQ_ABORT_EN defined, irq asserted in RUN SHALL be an abort condition.
REQ-029 Without VAPE_IRQ_ABORT_EN, irq SHALL be ignored.

Structure
REQ-030 A shared package vape_pkg SHALL hold the FSM state typedef and encodings, the RESET_HANDLER default, and the er_cycles width constant.
REQ-031 A sub-module vape_range_cmp SHALL implement the inclusive address-in-range check; it SHALL be instantiated three times (pc, data_addr, dma_addr).

Verification
REQ-032 Scenario: ER = 16'hE000..16'hE010; rst; pc = 0; pc steps E000..E010 -> exec = 1 one cycle after pc = E010; er_cycles = 17.
REQ-033 Scenario: in DONE (same ER), data_en = 1 with data_addr = 16'hE008 -> exec = 0 next cycle; state ABORT; er_cycles = 0.
REQ-034 Scenario: from IDLE, pc jumps to 16'hE004 -> ABORT; exec stays 0 until pc = 0 and then a full E000..E010 run.
REQ-035 Scenario: in RUN at pc = 16'hE006, dma_en = 1 with dma_addr = 16'h0200 -> ABORT; er_busy = 0 next cycle.
REQ-036 Scenario: in RUN, irq = 1 -> ABORT with VAPE_IRQ_ABORT_EN defined; run completes with exec = 1 without it.
REQ-037 Scenario: ER_min = 16'hE010, ER_max = 16'hE000 -> state stays ABORT, exec = 0 for any pc stream.
